sw_led_ctrl: RTL and testbench

- Parametrised successor to the board switch-to-LED passthrough: N_CH switch inputs, each synchronised and debounced independently, driving registered LED outputs.
- Selectable display mode: direct, toggle-on-press, inverted, or blink.
- Sits at the board I/O edge between the raw slide/push switches and the LED pins.
- Also exports debounced levels and press pulses to downstream logic.

---
 rtl/sw_led_pkg.sv | 19 +
 rtl/sw_debounce.sv | 63 ++++++
 rtl/sw_led_ctrl.sv | 97 +++++++++
 tb/tb_sw_led_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sw_led_pkg.sv
// Shared types and default parameters for the switch-to-LED controller.
// Latency: none. This package holds declarations only.
// Backpressure: none. This package holds declarations only.
package sw_led_pkg;

  // Display mode encoding as seen on mode_i.
  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_INVERT = 2'b11
  } mode_e;

  localparam int unsigned DEF_N_CH              = 7;
  localparam int unsigned DEF_SYNC_STAGES       = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 16;
  localparam int unsigned DEF_BLINK_HALF_PERIOD = 8;

endpackage

// File: rtl/sw_debounce.sv
// One channel: synchroniser chain, debounce counter, stable level and press pulse.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from a sw_i edge to stable_o. press_o rises together with stable_o.
// Backpressure: none; the block is free-running.
// Ports: clk_i/rst_i (sync active-high), sw_i raw level, stable_o debounced level,
//        press_o one-cycle pulse on each accepted 0->1 change.
module sw_debounce
  import sw_led_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic stable_o,
  output logic press_o
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   press_q, press_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any cycle where sync agrees with the stable level clears the count,
  // so a bounce gets no partial credit toward acceptance.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync;
        press_d  = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/sw_led_ctrl.sv
// N_CH debounced switches driving registered LEDs in DIRECT/TOGGLE/BLINK/INVERT mode.
// Latency: led_o follows sw_stable_o by one edge. A mode_i change reaches led_o one edge later.
// Backpressure: none; the block is free-running.
// Ports: clk_i/rst_i (sync active-high), sw_i raw switches, mode_i display mode,
//        led_o LED drive, sw_stable_o debounced levels, press_o press pulses.
// Build option: define SW_LED_BLINK_EN to add the blink counter. Without it, BLINK acts as DIRECT.
module sw_led_ctrl
  import sw_led_pkg::*;
#(
  parameter int unsigned N_CH              = DEF_N_CH,
  parameter int unsigned SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned BLINK_HALF_PERIOD = DEF_BLINK_HALF_PERIOD
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] sw_i,
  input  logic [1:0]      mode_i,
  output logic [N_CH-1:0] led_o,
  output logic [N_CH-1:0] sw_stable_o,
  output logic [N_CH-1:0] press_o
);

  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] tgl_q, tgl_d;
  logic [N_CH-1:0] led_q, led_d;
  logic [N_CH-1:0] blink_mask;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sw_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .sw_i    (sw_i[c]),
      .stable_o(stable[c]),
      .press_o (press[c])
    );
  end

  // The pulse visible this cycle is folded in now. A press and a switch into
  // TOGGLE in the same cycle therefore both show on the next edge.
  assign tgl_d = tgl_q ^ press;

`ifdef SW_LED_BLINK_EN
  localparam int unsigned   BW         = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

  logic [BW-1:0] bcnt_q;
  logic          phase_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (bcnt_q == BLINK_LAST) begin
      bcnt_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      bcnt_q  <= bcnt_q + 1'b1;
    end
  end

  assign blink_mask = {N_CH{phase_q}};
`else
  // An all-ones mask makes BLINK identical to DIRECT.
  assign blink_mask = '1;
`endif

  always_comb begin
    led_d = stable;
    case (mode_e'(mode_i))
      MODE_DIRECT: led_d = stable;
      MODE_TOGGLE: led_d = tgl_d;
      MODE_BLINK:  led_d = stable & blink_mask;
      MODE_INVERT: led_d = ~stable;
      default:     led_d = stable;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tgl_q <= '0;
      led_q <= '0;
    end else begin
      tgl_q <= tgl_d;
      led_q <= led_d;
    end
  end

  assign led_o       = led_q;
  assign sw_stable_o = stable;
  assign press_o     = press;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed bench for sw_led_ctrl with a per-cycle behavioural model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_sw_led_ctrl;

  localparam int N   = 7;
  localparam int SY  = 2;
  localparam int DC  = 4;
  localparam int BHP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw;
  logic [1:0]   mode;
  logic [N-1:0] led_o, sw_stable_o, press_o;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  sw_led_ctrl #(
    .N_CH             (N),
    .SYNC_STAGES      (SY),
    .DEBOUNCE_CYCLES  (DC),
    .BLINK_HALF_PERIOD(BHP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sw_i       (sw),
    .mode_i     (mode),
    .led_o      (led_o),
    .sw_stable_o(sw_stable_o),
    .press_o    (press_o)
  );

  // Model. A channel accepts a new level once the input, delayed by the
  // synchroniser depth, has disagreed with the stable level for DC edges in a row.
  // The toggle LED is the parity of the presses accepted so far.
  // The blink phase is derived from the number of edges since reset.
  logic [N-1:0] hist [SY];
  logic [N-1:0] m_stable, m_press, m_led;
  int           run    [N];
  int           pcount [N];
  int           n_edges;

  always @(posedge clk) begin : model
    logic [N-1:0] d, nled, tg;
`ifdef SW_LED_BLINK_EN
    logic ph;
`endif
    if (rst) begin
      for (int i = 0; i < SY; i++) hist[i] = '0;
      for (int c = 0; c < N; c++) begin run[c] = 0; pcount[c] = 0; end
      m_stable = '0; m_press = '0; m_led = '0; n_edges = 0;
    end else begin
      d = hist[SY-1];
      for (int c = 0; c < N; c++) tg[c] = (pcount[c] % 2) == 1;
      case (mode)
        2'b00:   nled = m_stable;
        2'b01:   nled = tg;
        2'b11:   nled = ~m_stable;
        default: begin
`ifdef SW_LED_BLINK_EN
          ph   = ((n_edges / BHP) % 2) == 1;
          nled = ph ? m_stable : '0;
`else
          nled = m_stable;
`endif
        end
      endcase
      m_press = '0;
      for (int c = 0; c < N; c++) begin
        if (d[c] != m_stable[c]) begin
          run[c]++;
          if (run[c] == DC) begin
            m_stable[c] = d[c];
            run[c]      = 0;
            if (d[c]) begin m_press[c] = 1'b1; pcount[c]++; end
          end
        end else begin
          run[c] = 0;
        end
      end
      for (int i = SY - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sw;
      m_led   = nled;
      n_edges++;
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait for the next negedge, then compare every output with the model.
  task automatic tick();
    @(negedge clk);
    chk("model_led",    led_o,       m_led);
    chk("model_stable", sw_stable_o, m_stable);
    chk("model_press",  press_o,     m_press);
  endtask

  int pcnt, c05, c00, exp05;

  initial begin
    rst = 1'b1; sw = 7'h7F; mode = 2'b00;
    // Reset with all switches high.
    repeat (3) tick();
    chk("rst_led", led_o, '0);
    chk("rst_stable", sw_stable_o, '0);
    chk("rst_press", press_o, '0);
    rst = 1'b0; sw = '0;
    tick();
    chk("post_rst_led", led_o, '0);
    chk("post_rst_stable", sw_stable_o, '0);

    // Clean edge in DIRECT mode.
    sw = 7'h01;
    repeat (5) tick();
    chk("t2_stable_e5", sw_stable_o, 7'h00);
    tick();
    chk("t2_stable_e6", sw_stable_o, 7'h01);
    chk("t2_press_e6", press_o, 7'h01);
    chk("t2_led_e6", led_o, 7'h00);
    tick();
    chk("t2_led_e7", led_o, 7'h01);
    chk("t2_press_e7", press_o, 7'h00);

    // Bounce on channel 3, then a clean rise.
    pcnt = 0;
    repeat (2) begin
      sw[3] = 1'b1; repeat (2) begin tick(); pcnt += int'(press_o[3]); end
      sw[3] = 1'b0; repeat (2) begin tick(); pcnt += int'(press_o[3]); end
    end
    chk("t3_no_accept", sw_stable_o, 7'h01);
    sw[3] = 1'b1;
    repeat (5) begin tick(); pcnt += int'(press_o[3]); end
    chk("t3_stable_e5", sw_stable_o, 7'h01);
    tick(); pcnt += int'(press_o[3]);
    chk("t3_stable_e6", sw_stable_o, 7'h09);
    repeat (4) begin tick(); pcnt += int'(press_o[3]); end
    chk("t3_one_press", (pcnt == 1) ? 7'h01 : 7'h00, 7'h01);

    // TOGGLE mode: channel 2 pressed three times.
    mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      sw[2] = 1'b1;
      repeat (10) tick();
      chk("t4_held", led_o & 7'h04, (i % 2 == 0) ? 7'h04 : 7'h00);
      sw[2] = 1'b0;
      repeat (10) tick();
      chk("t4_released", led_o & 7'h04, (i % 2 == 0) ? 7'h04 : 7'h00);
    end

    // INVERT, then BLINK.
    sw = 7'h05;
    repeat (10) tick();
    chk("t5_stable", sw_stable_o, 7'h05);
    mode = 2'b11;
    tick();
    chk("t5_invert", led_o, 7'h7A);
    mode = 2'b10;
    c05 = 0; c00 = 0;
    repeat (12) begin
      tick();
      if (led_o == 7'h05) c05++;
      if (led_o == 7'h00) c00++;
    end
`ifdef SW_LED_BLINK_EN
    exp05 = 6;
`else
    exp05 = 12;
`endif
    chk("t5_blink_on", 7'(c05), 7'(exp05));
    chk("t5_blink_off", 7'(c00), 7'(12 - exp05));

    // Reset pulse in the middle of a debounce count.
    mode = 2'b00;
    sw = 7'h07;
    repeat (4) tick();
    chk("t6_pre_rst", sw_stable_o & 7'h02, 7'h00);
    rst = 1'b1;
    tick();
    chk("t6_in_rst", sw_stable_o, 7'h00);
    rst = 1'b0;
    repeat (5) tick();
    chk("t6_e5", sw_stable_o & 7'h02, 7'h00);
    tick();
    chk("t6_e6", sw_stable_o, 7'h07);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
